// File: rtl/rsa_exp_ctrl.sv
// Sequencer for left-to-right binary modular exponentiation built on an
// external Montgomery multiplier. It converts M into the Montgomery domain,
// walks the exponent MSB-first issuing square and conditional multiply
// operations, then converts the result back out via a multiply by ONE.
module rsa_exp_ctrl #(
  parameter int EXP_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W-1:0]       exp,
  input  logic [$clog2(EXP_W):0] exp_len,
  output logic                   mm_start,
  output logic [2:0]             mm_sel_a,
  output logic [2:0]             mm_sel_b,
  output logic                   mm_dst,
  input  logic                   mm_done,
  output logic                   a_init,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             op_cnt
);

  localparam int IW = $clog2(EXP_W);
  localparam int LW = IW + 1;

  // Operand source encoding shared by both multiplier inputs.
  localparam logic [2:0] SRC_M   = 3'd0;
  localparam logic [2:0] SRC_R2  = 3'd1;
  localparam logic [2:0] SRC_A   = 3'd2;
  localparam logic [2:0] SRC_X   = 3'd3;
  localparam logic [2:0] SRC_ONE = 3'd4;

  typedef enum logic [3:0] {
    IDLE, X_ISS, X_WT, SQ_ISS, SQ_WT, MU_ISS, MU_WT, FN_ISS, FN_WT, DONE
  } state_t;

  typedef struct packed {
    logic       mm_start;
    logic       a_init;
    logic       busy;
    logic       done;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       dst;
  } out_t;

  state_t           state, state_n;
  logic [EXP_W-1:0] exp_q;
  logic [IW-1:0]    idx;
  logic             len_zero;
  logic [LW-1:0]    len_eff;
  logic             more_bits;
  logic             leave_wt_to_sq;

  // Moore output table; ISS and WT states of one operation share selects so
  // the operands stay stable for the whole multiplication.
  function automatic out_t decode(input state_t s);
    out_t o;
    o = '0;
    case (s)
      X_ISS, X_WT: begin
        o.mm_start = (s == X_ISS);
        o.a_init   = (s == X_ISS);
        o.busy     = 1'b1;
        o.sel_a    = SRC_M;
        o.sel_b    = SRC_R2;
        o.dst      = 1'b0;
      end
      SQ_ISS, SQ_WT: begin
        o.mm_start = (s == SQ_ISS);
        o.busy     = 1'b1;
        o.sel_a    = SRC_A;
        o.sel_b    = SRC_A;
        o.dst      = 1'b1;
      end
      MU_ISS, MU_WT: begin
        o.mm_start = (s == MU_ISS);
        o.busy     = 1'b1;
        o.sel_a    = SRC_A;
        o.sel_b    = SRC_X;
        o.dst      = 1'b1;
      end
      FN_ISS, FN_WT: begin
        o.mm_start = (s == FN_ISS);
        o.busy     = 1'b1;
        o.sel_a    = SRC_A;
        o.sel_b    = SRC_ONE;
        o.dst      = 1'b1;
      end
      DONE: begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Requested length clamped to the exponent register width.
  assign len_eff   = (exp_len > LW'(EXP_W)) ? LW'(EXP_W) : exp_len;
  assign more_bits = (idx != '0);

  // Next-state selection from the current state, mm_done and the exponent bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = X_ISS;
      X_ISS:  state_n = X_WT;
      X_WT:   if (mm_done) state_n = len_zero ? FN_ISS : SQ_ISS;
      SQ_ISS: state_n = SQ_WT;
      SQ_WT:  if (mm_done) begin
                if (exp_q[idx])     state_n = MU_ISS;
                else if (more_bits) state_n = SQ_ISS;
                else                state_n = FN_ISS;
              end
      MU_ISS: state_n = MU_WT;
      MU_WT:  if (mm_done) state_n = more_bits ? SQ_ISS : FN_ISS;
      FN_ISS: state_n = FN_WT;
      FN_WT:  if (mm_done) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The bit index moves to the next bit only when another square follows.
  assign leave_wt_to_sq = ((state == SQ_WT) || (state == MU_WT)) && (state_n == SQ_ISS);

  // State, operand latches, bit index, op counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exp_q    <= '0;
      idx      <= '0;
      len_zero <= 1'b0;
      op_cnt   <= '0;
      {mm_start, a_init, busy, done, mm_sel_a, mm_sel_b, mm_dst} <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_n;
      // Outputs are registered from the next state, so they match a decode of
      // the current state while coming straight from flops.
      {mm_start, a_init, busy, done, mm_sel_a, mm_sel_b, mm_dst} <= decode(state_n);

      if (state == IDLE && start) begin
        exp_q    <= exp;
        len_zero <= (len_eff == '0);
        idx      <= (len_eff == '0) ? '0 : IW'(len_eff - LW'(1));
        op_cnt   <= '0;
      end else begin
        if (mm_start && (op_cnt != 8'hFF)) op_cnt <= op_cnt + 8'd1;
        if (leave_wt_to_sq && more_bits)   idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: a behavioural multiplier with plain modular
// arithmetic answers each launched operation, and every run is compared
// against the operation list and power derived directly from the exponent.
module tb_rsa_exp_ctrl;

  localparam int EXP_W = 32;
  localparam int LW    = $clog2(EXP_W) + 1;

  // Operation codes: sel_a*100 + sel_b*10 + dst.
  localparam int OP_X  = 10;
  localparam int OP_SQ = 221;
  localparam int OP_MU = 231;
  localparam int OP_FN = 241;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             start_glitch = 1'b0;
  logic [EXP_W-1:0] exp_i = '0;
  logic [LW-1:0]    exp_len_i = '0;
  logic             mm_start;
  logic [2:0]       mm_sel_a, mm_sel_b;
  logic             mm_dst;
  logic             mm_done = 1'b0;
  logic             a_init, busy, done;
  logic [7:0]       op_cnt;

  rsa_exp_ctrl #(.EXP_W(EXP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start_i | start_glitch),
    .exp      (exp_i),
    .exp_len  (exp_len_i),
    .mm_start (mm_start),
    .mm_sel_a (mm_sel_a),
    .mm_sel_b (mm_sel_b),
    .mm_dst   (mm_dst),
    .mm_done  (mm_done),
    .a_init   (a_init),
    .busy     (busy),
    .done     (done),
    .op_cnt   (op_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Behavioural multiplier/datapath state.
  longint unsigned mod_n, msg, a_r, x_t, res_pend;
  bit              dst_pend;
  int              dly = 2;
  int              pending = 0;
  bit              inj_en = 0, inj_used = 0, glitch_next = 0;
  bit              done_seen = 0;
  int              stab_err = 0;
  logic [2:0]      last_a, last_b;
  logic            last_dst;
  int              obs_ops[$];

  function automatic longint unsigned operand(input logic [2:0] s);
    case (s)
      3'd0: return msg;
      3'd2: return a_r;
      3'd3: return x_t;
      default: return 64'd1;
    endcase
  endfunction

  // Answers each mm_start after dly cycles and injects the optional glitches.
  always @(negedge clk) begin
    mm_done = 1'b0;
    start_glitch = 1'b0;
    if (rst) begin
      pending = 0;
      glitch_next = 0;
    end else begin
      if (glitch_next) begin
        start_glitch = 1'b1;
        glitch_next = 0;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          mm_done = 1'b1;
          if (dst_pend) a_r = res_pend; else x_t = res_pend;
        end
      end
      if (mm_start) begin
        obs_ops.push_back(int'(mm_sel_a) * 100 + int'(mm_sel_b) * 10 + int'(mm_dst));
        if (a_init) a_r = 1;
        res_pend = (operand(mm_sel_a) * operand(mm_sel_b)) % mod_n;
        dst_pend = mm_dst;
        pending  = dly;
        last_a = mm_sel_a; last_b = mm_sel_b; last_dst = mm_dst;
        if (inj_en && mm_sel_b == 3'd2 && !inj_used) begin
          mm_done = 1'b1;
          glitch_next = 1;
          inj_used = 1;
        end
      end else if (busy && !done) begin
        if (mm_sel_a !== last_a || mm_sel_b !== last_b || mm_dst !== last_dst) stab_err++;
      end
      if (done) done_seen = 1;
    end
  end

  function automatic longint unsigned pow_mod(input longint unsigned m, input logic [EXP_W-1:0] e,
                                              input longint unsigned n);
    longint unsigned r = 1 % n;
    longint unsigned b = m % n;
    for (int i = 0; i < EXP_W; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  task automatic run(input string tag, input logic [EXP_W-1:0] e, input int len, input int d,
                     input bit inj);
    int               exp_ops[$];
    int               l;
    int               t0, dc;
    bit               got, same;
    logic [EXP_W-1:0] e_eff;
    l = (len > EXP_W) ? EXP_W : len;
    e_eff = '0;
    exp_ops.push_back(OP_X);
    for (int i = l - 1; i >= 0; i--) begin
      exp_ops.push_back(OP_SQ);
      if (e[i]) exp_ops.push_back(OP_MU);
      e_eff[i] = e[i];
    end
    exp_ops.push_back(OP_FN);
    mod_n = 64'($urandom_range(65521, 3));
    msg   = 64'($urandom_range(int'(mod_n) - 1, 0));
    obs_ops.delete();
    stab_err = 0;
    dly = d;
    inj_en = inj;
    inj_used = 0;
    got = 0;
    dc = 0;
    @(negedge clk);
    exp_i = e;
    exp_len_i = LW'(len);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_i = 1'b0;
    exp_i = $urandom;
    exp_len_i = LW'($urandom);
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        dc = cyc - t0 + 1;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_done_cycle"}, 64'(dc), 64'(exp_ops.size() * (d + 1) + 1));
    check({tag, "_op_cnt"}, 64'(op_cnt), 64'(exp_ops.size()));
    same = (obs_ops.size() == exp_ops.size());
    if (same) foreach (exp_ops[i]) if (obs_ops[i] != exp_ops[i]) same = 0;
    check({tag, "_op_seq"}, 64'(same), 64'd1);
    check({tag, "_result"}, a_r, pow_mod(msg, e_eff, mod_n));
    check({tag, "_sel_stable"}, 64'(stab_err), 64'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_op_cnt_hold"}, 64'(op_cnt), 64'(exp_ops.size()));
  endtask

  initial begin
    int k;
    bit hit;
    mod_n = 97;
    msg = 5;
    #12;
    check("reset_ctrl", {58'd0, mm_start, a_init, busy, done, mm_dst, done_seen}, 64'd0);
    check("reset_sel", {58'd0, mm_sel_a, mm_sel_b}, 64'd0);
    check("reset_op_cnt", 64'(op_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("ex5_len3", 32'd5, 3, 2, 0);
    run("ex9985", 32'h9985, 16, 3, 0);
    run("len0", $urandom, 0, 2, 0);
    run("glitch", $urandom | 32'h80, 8, 2, 1);

    // Abort in MU_WT, then a fresh small run.
    inj_en = 0;
    dly = 3;
    done_seen = 0;
    @(negedge clk);
    exp_i = '1;
    exp_len_i = LW'(4);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    hit = 0;
    k = 0;
    while (!hit && k < 500) begin
      @(negedge clk);
      k++;
      if (busy && !mm_start && mm_sel_b == 3'd3) hit = 1;
    end
    check("abort_reach_mu_wt", 64'(hit), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl_zero", {60'd0, mm_start, a_init, busy, done}, 64'd0);
    check("abort_sel_zero", {57'd0, mm_sel_a, mm_sel_b, mm_dst}, 64'd0);
    check("abort_op_cnt_zero", 64'(op_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'd0);
    run("after_abort", 32'd1, 1, 2, 0);

    run("clamp", '1, EXP_W + 5, 1, 0);
    check("clamp_op_cnt", 64'(op_cnt), 64'(2 * EXP_W + 2));

    for (int r = 0; r < 6; r++)
      run($sformatf("rand%0d", r), $urandom, int'($urandom_range(EXP_W + 3, 0)),
          int'($urandom_range(4, 1)), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
